if_pc_gen: RTL and testbench
============================

IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 The block SHALL have parameter BTB_ENTRIES, default 8, number of branch target buffer (BTB) entries; power of two, minimum 2; IDX = log2(BTB_ENTRIES).
REQ-003 Port: clk  input  1  rising-edge clock; the only clock.
REQ-004 Port: reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 Port: PC_Stall  input  1  1 = hold PC (load-use hazard).
REQ-006 Port: PCSrc  input  1  1 = redirect from EX (mispredict or resolved jump).
REQ-007 Port: PC_target  input  32  redirect address; bits [1:0] ignored.
REQ-008 Port: upd_valid  input  1  BTB update strobe from EX.
REQ-009 Port: upd_pc  input  32  address of the resolved branch.
REQ-010 Port: upd_taken  input  1  resolved direction.
REQ-011 Port: upd_target  input  32  resolved target; bits [1:0] ignored.
REQ-012 Port: PC_out  output  32  registered fetch PC; drives the instruction memory's PC input.
REQ-013 Port: pred_taken  output  1  prediction for PC_out; pipelined by IF/ID for EX comparison.

Function
REQ-014 Next-PC priority SHALL be: reset > PCSrc (PC_target) > PC_Stall (hold) > predicted-taken (BTB target) > PC_out+4.
REQ-015 PCSrc SHALL redirect even when PC_Stall=1.
REQ-016 PC_out[1:0] SHALL always be 2'b00.
REQ-017 PC_out+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 BTB lookup SHALL be combinational on PC_out: index = PC_out[IDX+1:2], tag = PC_out[31:IDX+2]; hit = valid & tag match.
REQ-019 pred_taken SHALL equal hit & ctr[1], valid in the same cycle as PC_out.
REQ-020 Each entry SHALL hold valid, tag, target[31:2], 2-bit saturating counter ctr.
REQ-021 Update on upd_valid, at the entry indexed by upd_pc: on hit, ctr increments (saturating at 2'b11) if upd_taken, else decrements (saturating at 2'b00); target is overwritten only when upd_taken.
REQ-022 Update on miss (invalid or tag mismatch) with upd_taken=1 SHALL allocate: valid=1, new tag, target, ctr=2'b10; a miss with upd_taken=0 SHALL leave the entry unchanged.
REQ-023 Updates SHALL be applied regardless of PC_Stall and PCSrc.
REQ-024 Lookup and update on the same index in the same cycle: lookup SHALL use the pre-update contents; the update is visible from the next cycle.
REQ-025 Latency: a redirect or prediction presented before edge N SHALL appear on PC_out after edge N (one cycle).

Reset
REQ-026 While reset=0 at a rising edge: PC_out <= RESET_PC, all BTB valid bits <= 0, all ctr <= 2'b01.
REQ-027 pred_taken SHALL therefore be 0 in the first cycle after reset; reset SHALL override PCSrc, PC_Stall and upd_valid.
REQ-028 Reset asserted mid-operation SHALL discard all prediction state in that same edge.

Structure
REQ-029 A shared package SHALL hold RESET_PC default, the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the BTB entry record type.
REQ-030 The BTB SHALL be a sub-module named if_btb (lookup port plus update port); if_pc_gen holds the PC register and next-PC mux.

Verification
REQ-031 Reset release, no stall, empty BTB -> PC_out 0x0, 0x4, 0x8, 0xC on successive cycles; pred_taken=0.
REQ-032 PC_Stall=1 for 3 cycles at PC_out=0x10 -> PC_out stays 0x10, then 0x14; PC_Stall=1 with PCSrc=1, PC_target=0x40 -> PC_out=0x40 next cycle.
REQ-033 upd_valid, upd_pc=0x20, upd_taken=1, upd_target=0x80 -> the next fetch of 0x20 gives pred_taken=1, and the following PC_out=0x80.
REQ-034 Two not-taken updates at 0x20 (ctr 10->01->00) -> fetch of 0x20 gives pred_taken=0, next PC_out=0x24; one taken update -> still not predicted (ctr=01).
REQ-035 Aliasing, BTB_ENTRIES=8: entry allocated for 0x20; fetch 0x40 (same index, different tag) -> pred_taken=0; a same-cycle update at 0x20 while fetching 0x20 -> lookup uses the old contents.
REQ-036 PC_out=0xFFFF_FFFC, no hit -> PC_out=0x0; reset=0 mid-run with valid BTB entries -> PC_out=RESET_PC, all subsequent lookups miss.

Source files
------------

// File: rtl/if_pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// if_pc_gen_pkg
// Definitions shared by the fetch-stage PC generator and its branch target
// buffer (BTB):
//   RESET_PC_DEFAULT : default fetch address loaded on reset
//   ctr_e            : 2-bit saturating direction counter encodings
//   btb_entry_t      : one BTB entry (valid, tag, word target, counter)
//   pc_sel_e         : which source the next-PC mux selected (debug view)
//   ctr_next()       : saturating counter update
//   pc_tag()         : tag extraction for a given index width
// ---------------------------------------------------------------------------
package if_pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Widest tag in use is 32-2-1 = 29 bits (two entries); the field is kept
  // at 30 bits so one record type serves every legal BTB size. Unused upper
  // tag bits are always zero on both sides of the compare.
  localparam int unsigned TAG_W_MAX = 30;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not taken
    CTR_WNT = 2'b01,  // weakly not taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_MAX-1:0]  tag;
    logic [29:0]           target;  // target address bits [31:2]
    ctr_e                  ctr;
  } btb_entry_t;

  typedef enum logic [2:0] {
    SEL_RESET    = 3'd0,
    SEL_REDIRECT = 3'd1,
    SEL_HOLD     = 3'd2,
    SEL_PRED     = 3'd3,
    SEL_SEQ      = 3'd4
  } pc_sel_e;

  // Saturating increment on taken, saturating decrement on not taken.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      case (c)
        CTR_SNT: n = CTR_WNT;
        CTR_WNT: n = CTR_WT;
        CTR_WT:  n = CTR_ST;
        default: n = CTR_ST;
      endcase
    end else begin
      case (c)
        CTR_ST:  n = CTR_WT;
        CTR_WT:  n = CTR_WNT;
        CTR_WNT: n = CTR_SNT;
        default: n = CTR_SNT;
      endcase
    end
    return n;
  endfunction

  // Tag = pc[31:idx_w+2], zero-extended into the fixed-width tag field.
  function automatic logic [TAG_W_MAX-1:0] pc_tag(input logic [31:0] pc,
                                                  input int unsigned idx_w);
    logic [31:0] shifted;
    shifted = pc >> (idx_w + 2);
    return shifted[TAG_W_MAX-1:0];
  endfunction

  // A counter in either taken state predicts taken.
  function automatic logic ctr_taken(input ctr_e c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

endpackage

// File: rtl/if_btb.sv
// ---------------------------------------------------------------------------
// if_btb
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry.
//
// Ports
//   clk, reset              : clock, synchronous active-low reset
//   lk_pc                   : lookup address (the current fetch PC)
//   lk_hit                  : valid entry with matching tag
//   lk_taken                : lk_hit and counter predicts taken
//   lk_target               : predicted target (bits [1:0] forced to 0)
//   upd_valid               : update strobe from EX
//   upd_pc                  : address of the resolved branch
//   upd_taken               : resolved direction
//   upd_target              : resolved target (bits [1:0] ignored)
//
// Update strobe semantics: upd_valid is a single-cycle, always-accepted
// strobe (there is no ready); each cycle it is high exactly one update,
// described by upd_pc/upd_taken/upd_target, is committed at the next rising
// edge unless reset is low at that edge.
//
// BTB_ENTRIES must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module if_btb
  import if_pc_gen_pkg::*;
#(
  parameter int BTB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  btb_entry_t mem [BTB_ENTRIES];

  // ---------------------------------------------------------------------
  // Lookup: purely combinational on the registered array, so a lookup in
  // the same cycle as an update to the same index sees the old contents.
  // ---------------------------------------------------------------------
  logic [IDX-1:0] lk_idx;
  btb_entry_t     lk_e;

  assign lk_idx    = lk_pc[IDX+1:2];
  assign lk_e      = mem[lk_idx];
  assign lk_hit    = lk_e.valid && (lk_e.tag == pc_tag(lk_pc, IDX));
  assign lk_taken  = lk_hit && ctr_taken(lk_e.ctr);
  assign lk_target = {lk_e.target, 2'b00};

  // ---------------------------------------------------------------------
  // Update: compute the replacement entry for the indexed slot.
  // ---------------------------------------------------------------------
  logic [IDX-1:0]       u_idx;
  logic [TAG_W_MAX-1:0] u_tag;
  btb_entry_t           u_old;
  btb_entry_t           u_new;
  logic                 u_hit;
  logic                 u_we;

  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = pc_tag(upd_pc, IDX);
  assign u_old = mem[u_idx];
  assign u_hit = u_old.valid && (u_old.tag == u_tag);

  always_comb begin
    u_new = u_old;
    u_we  = 1'b0;
    if (upd_valid) begin
      if (u_hit) begin
        u_we      = 1'b1;
        u_new.ctr = ctr_next(u_old.ctr, upd_taken);
        // A not-taken outcome carries no useful target; keep the old one.
        if (upd_taken) begin
          u_new.target = upd_target[31:2];
        end
      end else if (upd_taken) begin
        // Allocate (or replace an aliasing entry) only for taken branches,
        // starting weakly taken so the very next fetch is redirected.
        u_we         = 1'b1;
        u_new.valid  = 1'b1;
        u_new.tag    = u_tag;
        u_new.target = upd_target[31:2];
        u_new.ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem[i].valid  <= 1'b0;
        mem[i].tag    <= '0;
        mem[i].target <= '0;
        mem[i].ctr    <= CTR_WNT;
      end
    end else if (u_we) begin
      mem[u_idx] <= u_new;
    end
  end

  // Byte-offset bits carry no information for word-aligned fetch.
  logic unused_btb_bits;
  assign unused_btb_bits = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: rtl/if_pc_gen.sv
// ---------------------------------------------------------------------------
// if_pc_gen
// Fetch-stage program counter generator with BTB-based branch prediction.
//
// Ports
//   clk         : rising-edge clock
//   reset       : synchronous active-low reset (0 = reset)
//   PC_Stall    : hold the PC (load-use hazard)
//   PCSrc       : redirect from EX to PC_target (wins over PC_Stall)
//   PC_target   : redirect address, bits [1:0] ignored
//   upd_valid   : BTB update strobe from EX
//   upd_pc      : address of the resolved branch
//   upd_taken   : resolved direction
//   upd_target  : resolved target, bits [1:0] ignored
//   PC_out      : registered fetch PC, always word aligned
//   pred_taken  : BTB prediction for PC_out, same cycle as PC_out
//
// Next-PC priority: reset > PCSrc > PC_Stall > predicted taken > PC_out+4.
// Every source takes effect on the PC one clock edge after it is presented.
// ---------------------------------------------------------------------------
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Stall,
  input  logic        PCSrc,
  input  logic [31:0] PC_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] PC_out,
  output logic        pred_taken
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  pc_sel_e     pc_sel;     // which mux leg drives pc_d this cycle
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_target;

  if_btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lk_pc      (pc_q),
    .lk_hit     (btb_hit),
    .lk_taken   (btb_taken),
    .lk_target  (btb_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  // Next-PC mux. Reset is handled in the register itself; pc_sel still
  // reports it so the selected source is observable every cycle.
  always_comb begin
    pc_d   = pc_q + 32'd4;   // wraps modulo 2^32
    pc_sel = SEL_SEQ;
    if (!reset) begin
      pc_d   = {RESET_PC[31:2], 2'b00};
      pc_sel = SEL_RESET;
    end else if (PCSrc) begin
      pc_d   = {PC_target[31:2], 2'b00};
      pc_sel = SEL_REDIRECT;
    end else if (PC_Stall) begin
      pc_d   = pc_q;
      pc_sel = SEL_HOLD;
    end else if (btb_taken) begin
      pc_d   = btb_target;
      pc_sel = SEL_PRED;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_out     = pc_q;
  assign pred_taken = btb_taken;

  // Kept for visibility only (hit without taken counter, mux select,
  // ignored redirect offset bits).
  logic unused_pc_gen;
  assign unused_pc_gen = ^{btb_hit, pc_sel, PC_target[1:0]};

endmodule

// File: tb/tb_if_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_if_pc_gen
// Directed checks of the fetch PC generator: a vector table of per-cycle
// inputs with hand-computed PC_out/pred_taken after the following edge,
// followed by a stall sequence of variable length with a BTB update inside.
// Default parameters: RESET_PC = 0, BTB_ENTRIES = 8 (index = PC[4:2]).
// ---------------------------------------------------------------------------
module tb_if_pc_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        PC_Stall;
  logic        PCSrc;
  logic [31:0] PC_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] PC_out;
  logic        pred_taken;

  if_pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .PC_Stall   (PC_Stall),
    .PCSrc      (PCSrc),
    .PC_target  (PC_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .PC_out     (PC_out),
    .pred_taken (pred_taken)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] epc;
    logic        epred;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {PC_out, pred_taken}
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic s, input logic p,
                     input logic [31:0] t, input logic uv,
                     input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic [31:0] epc,
                     input logic ep);
    vec_t v;
    v.rst_n = r;   v.stall = s;  v.src = p;    v.tgt = t;
    v.uv    = uv;  v.upc   = upc; v.ut = ut;   v.utgt = utgt;
    v.epc   = epc; v.epred = ep;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic s, input logic p,
                       input logic [31:0] t, input logic uv,
                       input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
    reset      = r;
    PC_Stall   = s;
    PCSrc      = p;
    PC_target  = t;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name);
    logic [32:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got PC_out=%h pred_taken=%b",
               name, PC_out, pred_taken);
      return;
    end
    e = exp_q.pop_front();
    if ({PC_out, pred_taken} !== e) begin
      errors++;
      $display("FAIL %s: got PC_out=%h pred_taken=%b, expected PC_out=%h pred_taken=%b",
               name, PC_out, pred_taken, e[32:1], e[0]);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int n_stall;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    //  rst stl src tgt            uv  upc           ut  utgt          exp_pc        pred
    add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0000, 0); // reset state
    add(0, 0, 1, 32'h100,        1, 32'h0,        1, 32'h40,       32'h0000_0000, 0); // reset beats redirect/update
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0004, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0008, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_000C, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0010, 0);
    add(1, 1, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0010, 0); // stall x3
    add(1, 1, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0010, 0);
    add(1, 1, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0010, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0014, 0);
    add(1, 1, 1, 32'h43,         0, 32'h0,        0, 32'h0,        32'h0000_0040, 0); // redirect beats stall, [1:0] dropped
    add(1, 0, 1, 32'h20,         1, 32'h20,       1, 32'h81,       32'h0000_0020, 1); // allocate 0x20 -> 0x80, ctr=10
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0080, 0); // predicted target
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0084, 0);
    add(1, 0, 1, 32'h40,         0, 32'h0,        0, 32'h0,        32'h0000_0040, 0); // alias of 0x20, tag differs
    add(1, 0, 0, 32'h0,          1, 32'h20,       0, 32'h0,        32'h0000_0044, 0); // ctr 10->01
    add(1, 0, 0, 32'h0,          1, 32'h20,       0, 32'h0,        32'h0000_0048, 0); // ctr 01->00
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0024, 0);
    add(1, 0, 1, 32'h20,         1, 32'h20,       1, 32'h80,       32'h0000_0020, 0); // ctr 00->01
    add(1, 0, 0, 32'h0,          1, 32'h20,       1, 32'h80,       32'h0000_0024, 0); // ctr 01->10
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 1);
    add(1, 0, 0, 32'h0,          1, 32'h20,       0, 32'h200,      32'h0000_0080, 0); // lookup uses old ctr=10
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 0); // ctr now 01
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0024, 0);
    add(1, 0, 0, 32'h0,          1, 32'h20,       1, 32'h90,       32'h0000_0028, 0); // 01->10, target 0x90
    add(1, 0, 0, 32'h0,          1, 32'h20,       1, 32'h90,       32'h0000_002C, 0); // 10->11
    add(1, 0, 0, 32'h0,          1, 32'h20,       0, 32'h300,      32'h0000_0030, 0); // 11->10, target kept
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 1);
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0090, 0);
    add(1, 0, 0, 32'h0,          1, 32'h20,       1, 32'h90,       32'h0000_0094, 0); // 10->11
    add(1, 0, 0, 32'h0,          1, 32'h20,       1, 32'h90,       32'h0000_0098, 0); // saturate 11
    add(1, 0, 0, 32'h0,          1, 32'h20,       1, 32'h90,       32'h0000_009C, 0); // saturate 11
    add(1, 0, 0, 32'h0,          1, 32'h20,       0, 32'h0,        32'h0000_00A0, 0); // 11->10
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 1);
    add(1, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 0); // redirect beats prediction
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0000, 0); // +4 wraps
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 1);
    add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0000, 0); // mid-run reset
    add(1, 0, 1, 32'h20,         0, 32'h0,        0, 32'h0,        32'h0000_0020, 0); // entry discarded
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0024, 0);
    add(1, 0, 0, 32'h0,          1, 32'h30,       0, 32'h60,       32'h0000_0028, 0); // miss + not taken: no alloc
    add(1, 0, 1, 32'h30,         0, 32'h0,        0, 32'h0,        32'h0000_0030, 0);
    add(1, 1, 0, 32'h0,          1, 32'h30,       1, 32'h60,       32'h0000_0030, 1); // alloc while stalled
    add(1, 1, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0030, 1); // stall beats prediction
    add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0000_0060, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].src, vecs[i].tgt,
            vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt);
      exp_q.push_back({vecs[i].epc, vecs[i].epred});
      tick();
      check($sformatf("vec%0d", i));
    end

    // Variable-length stall at 0x60 with a BTB allocation for 0x64 on the
    // first stalled cycle; the allocation must be in place at release.
    n_stall = $urandom_range(2, 5);
    for (int i = 0; i < n_stall; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, (i == 0), 32'h64, 1'b1, 32'h200);
      exp_q.push_back({32'h0000_0060, 1'b0});
      tick();
      check($sformatf("stall_hold%0d", i));
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_q.push_back({32'h0000_0064, 1'b1});
    tick();
    check("stall_release");
    exp_q.push_back({32'h0000_0200, 1'b0});
    tick();
    check("stall_pred_target");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
